// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S frame transmitter:
//   HDR_W / WORD_W  - header and payload word widths (bits)
//   i2s_state_t     - frame FSM state encoding
//   pack_header()   - builds the 16-bit frame header
//   word_count()    - payload word count, (nx+1)*(ny+1), 1..256
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } i2s_state_t;

    // Header layout: columns-1 | rows-1 | reserved 2'b00 | row field
    function automatic logic [HDR_W-1:0] pack_header(
        input logic [3:0] nx,
        input logic [3:0] ny,
        input logic [5:0] row
    );
        return {nx, ny, 2'b00, row};
    endfunction

    // Both factors are at most 16, so the product fits in 9 bits.
    function automatic logic [8:0] word_count(
        input logic [3:0] nx,
        input logic [3:0] ny
    );
        logic [8:0] cols;
        logic [8:0] rows;
        cols = {5'd0, nx} + 9'd1;
        rows = {5'd0, ny} + 9'd1;
        return cols * rows;
    endfunction

endpackage

// File: rtl/i2s_word_buf.sv
// ---------------------------------------------------------------------------
// i2s_word_buf
// One-entry holding register between the word source and the shifter.
//   clk, rst_n      - clock, asynchronous active-low reset
//   word_data/valid - incoming payload word and its valid flag
//   word_ready      - registered: holding register empty and acceptance enabled
//   accept_en_next  - from the FSM: acceptance allowed in the next cycle
//   pop             - shifter takes the word this cycle
//   word_taken      - a transfer happens this cycle (valid && ready)
//   buf_avail       - a word can be popped this cycle (stored or arriving)
//   buf_data        - the word that a pop would take
// A word arriving in the same cycle the shifter needs it is passed straight
// through, so a late source costs no idle bit slot.
// ---------------------------------------------------------------------------
module i2s_word_buf
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              accept_en_next,
    input  logic              pop,
    output logic              word_taken,
    output logic              buf_avail,
    output logic [WORD_W-1:0] buf_data
);

    logic              full_reg;
    logic              full_next;
    logic              ready_reg;
    logic [WORD_W-1:0] hold_reg;

    assign word_taken = word_valid & ready_reg;
    assign buf_avail  = full_reg | word_taken;
    assign buf_data   = full_reg ? hold_reg : word_data;
    assign word_ready = ready_reg;

    // ready is only ever high while empty, so push and a stored word never
    // coincide; a push popped in the same cycle leaves the register empty.
    always_comb begin
        full_next = full_reg;
        if (full_reg) begin
            full_next = ~pop;
        end else begin
            full_next = word_taken & ~pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg  <= 1'b0;
            ready_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            full_reg  <= full_next;
            ready_reg <= accept_en_next & ~full_next;
            if (word_taken && !pop) begin
                hold_reg <= word_data;
            end
        end
    end

endmodule

// File: rtl/i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// i2s_frame_tx
// Serialises one frame per start request: a 16-bit header followed by
// (num_modules_x+1)*(num_modules_y+1) 16-bit payload words, MSB first, one
// bit per cycle marked by i2s_clk_en.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - frame request, honoured only in IDLE
//   num_modules_x/y       - columns-1 / rows-1, latched at start
//   word_data/valid/ready - payload word handshake
//   i2s_data, i2s_clk_en  - serial bit and its slot marker
//   busy, frame_done      - frame in progress / one-cycle end pulse
//   row_num               - row field for the next frame, wraps at ROW_COUNT
//   underrun              - sticky starvation flag
// Build option: define I2S_FRAME_TX_STALL_EN to pause the bitstream when the
// next word is missing; otherwise a missing word is sent as zeros and flagged.
// ---------------------------------------------------------------------------
module i2s_frame_tx
    import i2s_pkg::*;
#(
    parameter int ROW_COUNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        num_modules_x,
    input  logic [3:0]        num_modules_y,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              i2s_data,
    output logic              i2s_clk_en,
    output logic              busy,
    output logic              frame_done,
    output logic [5:0]        row_num,
    output logic              underrun
);

    i2s_state_t        state_reg, state_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;       // bits of current word already emitted, mod 16
    logic [8:0]        words_sent_reg, words_sent_next; // payload slots started
    logic [8:0]        accept_cnt_reg, accept_cnt_next; // words accepted plus starved slots
    logic [8:0]        n_words_reg, n_words_next;
    logic              data_reg, data_next;
    logic              clk_en_reg, clk_en_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [5:0]        row_reg, row_next;
    logic              underrun_reg, underrun_next;

    logic [HDR_W-1:0]  hdr_word;
    logic              buf_pop;
    logic              buf_avail;
    logic              word_taken;
    logic [WORD_W-1:0] buf_data;
    logic              accept_en_next;

    assign hdr_word = pack_header(num_modules_x, num_modules_y, row_reg);

    i2s_word_buf u_word_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .accept_en_next (accept_en_next),
        .pop            (buf_pop),
        .word_taken     (word_taken),
        .buf_avail      (buf_avail),
        .buf_data       (buf_data)
    );

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        words_sent_next = words_sent_reg;
        accept_cnt_next = accept_cnt_reg + 9'(word_taken);
        n_words_next    = n_words_reg;
        data_next       = 1'b0;
        clk_en_next     = 1'b0;
        row_next        = row_reg;
        underrun_next   = underrun_reg;
        buf_pop         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next      = ST_HEADER;
                    data_next       = hdr_word[HDR_W-1];
                    shift_next      = {hdr_word[HDR_W-2:0], 1'b0};
                    clk_en_next     = 1'b1;
                    bit_cnt_next    = 4'd1;
                    words_sent_next = 9'd0;
                    accept_cnt_next = 9'd0;
                    n_words_next    = word_count(num_modules_x, num_modules_y);
                    underrun_next   = 1'b0;
                end
            end

            ST_HEADER, ST_PAYLOAD: begin
                if (bit_cnt_reg != 4'd0) begin
                    // mid-word: emit the next bit
                    data_next    = shift_reg[WORD_W-1];
                    shift_next   = {shift_reg[WORD_W-2:0], 1'b0};
                    clk_en_next  = 1'b1;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end else if (words_sent_reg == n_words_reg) begin
                    // word boundary after the last payload word (never true in HEADER)
                    state_next = ST_DONE;
                    row_next   = (row_reg == 6'(ROW_COUNT - 1)) ? 6'd0 : row_reg + 6'd1;
                end else if (buf_avail) begin
                    state_next      = ST_PAYLOAD;
                    buf_pop         = 1'b1;
                    data_next       = buf_data[WORD_W-1];
                    shift_next      = {buf_data[WORD_W-2:0], 1'b0};
                    clk_en_next     = 1'b1;
                    bit_cnt_next    = 4'd1;
                    words_sent_next = words_sent_reg + 9'd1;
                end else begin
`ifdef I2S_FRAME_TX_STALL_EN
                    // starved: freeze at the boundary, keep the line steady
                    data_next = data_reg;
`else
                    // starved: the slot goes out as zeros and counts as consumed,
                    // so later words move up one slot
                    state_next      = ST_PAYLOAD;
                    shift_next      = '0;
                    clk_en_next     = 1'b1;
                    bit_cnt_next    = 4'd1;
                    words_sent_next = words_sent_reg + 9'd1;
                    accept_cnt_next = accept_cnt_reg + 9'd1;
                    underrun_next   = 1'b1;
`endif
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    assign accept_en_next = ((state_next == ST_HEADER) || (state_next == ST_PAYLOAD))
                            && (accept_cnt_next < n_words_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= 4'd0;
            words_sent_reg <= 9'd0;
            accept_cnt_reg <= 9'd0;
            n_words_reg    <= 9'd0;
            data_reg       <= 1'b0;
            clk_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            row_reg        <= 6'd0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            words_sent_reg <= words_sent_next;
            accept_cnt_reg <= accept_cnt_next;
            n_words_reg    <= n_words_next;
            data_reg       <= data_next;
            clk_en_reg     <= clk_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            row_reg        <= row_next;
            underrun_reg   <= underrun_next;
        end
    end

    assign i2s_data   = data_reg;
    assign i2s_clk_en = clk_en_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
    assign row_num    = row_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_tx
// Scoreboard bench for i2s_frame_tx: each frame pushes its expected header and
// payload words into a queue; a monitor rebuilds 16-bit words from the serial
// stream and compares them in order. Frame-level timing, stall/underrun
// behaviour, row numbering and reset behaviour are checked alongside.
// Honours I2S_FRAME_TX_STALL_EN for the starvation expectations.
// ---------------------------------------------------------------------------
module tb_i2s_frame_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  num_modules_x;
    logic [3:0]  num_modules_y;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        i2s_data;
    logic        i2s_clk_en;
    logic        busy;
    logic        frame_done;
    logic [5:0]  row_num;
    logic        underrun;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_q[$];
    bit          stop_src;
    bit          all_taken;
    int          exp_row;
    bit          uf_prev;

    i2s_frame_tx #(.ROW_COUNT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_modules_x (num_modules_x),
        .num_modules_y (num_modules_y),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .i2s_data      (i2s_data),
        .i2s_clk_en    (i2s_clk_en),
        .busy          (busy),
        .frame_done    (frame_done),
        .row_num       (row_num),
        .underrun      (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Monitor: rebuild words from enabled bit slots, compare against the queue.
    initial begin : monitor
        logic [15:0] mon_word;
        int          mon_n;
        mon_word = '0;
        mon_n    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_n = 0;
            end else if (i2s_clk_en) begin
                mon_word = {mon_word[14:0], i2s_data};
                mon_n++;
                if (mon_n == 16) begin
                    mon_n = 0;
                    if (exp_q.size() == 0) check_val("word_expected", 32'(exp_q.size()), 32'd1);
                    else check_val("word", {16'd0, mon_word}, {16'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic run_frame(input int nx, input int ny, input logic [15:0] base,
                             input logic [15:0] stride, input int stall_word,
                             input int inj_cyc, input int rst_cyc);
        logic [15:0] src[256];
        int          n;
        int          exp_stall;
        bit          exp_uf;
        int          release_cyc;
        int          lat_exp;
        int          en_cnt;
        int          low_cnt;
        int          late;
        bit          done_seen;
        bit          aborted;

        n = (nx + 1) * (ny + 1);
        for (int k = 0; k < n; k++) src[k] = base + 16'(k) * stride;

        exp_q.push_back({4'(nx), 4'(ny), 2'b00, 6'(exp_row)});
`ifdef I2S_FRAME_TX_STALL_EN
        for (int k = 0; k < n; k++) exp_q.push_back(src[k]);
        exp_stall = (stall_word > 0) ? 5 : 0;
        exp_uf    = 1'b0;
`else
        for (int k = 0; k < n; k++) begin
            if (stall_word > 0 && k + 1 == stall_word) exp_q.push_back(16'h0000);
            else if (stall_word > 0 && k + 1 > stall_word) exp_q.push_back(src[k-1]);
            else exp_q.push_back(src[k]);
        end
        exp_stall = 0;
        exp_uf    = (stall_word > 0);
`endif
        release_cyc = (stall_word > 0) ? 16 + (stall_word - 1) * 16 + 5 : 0;
        lat_exp     = 17 + n * 16 + exp_stall;
        en_cnt = 0; low_cnt = 0; late = 0; done_seen = 0; aborted = 0;
        stop_src = 0; all_taken = 0;

        $display("frame nx=%0d ny=%0d row=%0d words=%0d stall_word=%0d", nx, ny, exp_row, n, stall_word);

        @(negedge clk);
        check_val("underrun_hold", {31'd0, underrun}, {31'd0, uf_prev});
        start = 1'b1;
        num_modules_x = 4'(nx);
        num_modules_y = 4'(ny);

        fork
            begin : src_proc
                int idx;
                bit prev;
                int cyc_s;
                idx = 0; prev = 0; cyc_s = 0;
                while (!stop_src && idx < n && cyc_s < 5000) begin
                    @(negedge clk);
                    cyc_s++;
                    if (prev) idx++;
                    if (idx >= n) begin
                        all_taken  = 1'b1;
                        word_valid = 1'b0;
                    end else begin
                        word_data  = src[idx];
                        word_valid = !(stall_word > 0 && idx + 1 == stall_word && cyc_s < release_cyc);
                        prev       = word_valid && word_ready;
                    end
                end
                word_valid = 1'b0;
            end
            begin : watch_proc
                int cyc_w;
                cyc_w = 0;
                while (!done_seen && !aborted && cyc_w < 5000) begin
                    @(negedge clk);
                    cyc_w++;
                    if (cyc_w == 1) start = 1'b0;
                    if (inj_cyc > 0 && cyc_w == inj_cyc) begin
                        start = 1'b1;
                        num_modules_x = ~4'(nx);
                    end
                    if (inj_cyc > 0 && cyc_w == inj_cyc + 1) begin
                        start = 1'b0;
                        num_modules_x = 4'(nx);
                    end
                    if (rst_cyc > 0 && cyc_w == rst_cyc) begin
                        check_val("row_hold", {26'd0, row_num}, 32'(exp_row));
                        check_val("en_before_rst", {31'd0, i2s_clk_en}, 32'd1);
                        #2 rst_n = 1'b0;
                        #1 check_val("rst_async",
                                     {20'd0, word_ready, i2s_data, i2s_clk_en, busy, frame_done, underrun, row_num},
                                     32'd0);
                        aborted = 1'b1;
                    end else begin
                        if (cyc_w == 1) check_val("first_bit", {29'd0, busy, i2s_clk_en, underrun}, 32'b110);
                        if (i2s_clk_en) en_cnt++;
                        if (busy && !frame_done && !i2s_clk_en) low_cnt++;
                        if (all_taken && word_ready) late++;
                        if (frame_done) begin
                            done_seen = 1'b1;
                            check_val("done_latency", 32'(cyc_w), 32'(lat_exp));
                            check_val("done_outs", {29'd0, busy, i2s_clk_en, i2s_data}, 32'b100);
                        end
                    end
                end
                stop_src = 1'b1;
            end
        join

        if (!aborted) begin
            check_val("frame_done_seen", {31'd0, done_seen}, 32'd1);
            check_val("en_cycles", 32'(en_cnt), 32'(16 + 16 * n));
            check_val("stall_cycles", 32'(low_cnt), 32'(exp_stall));
            check_val("late_ready", 32'(late), 32'd0);
            check_val("row_after", {26'd0, row_num}, 32'((exp_row + 1) % 8));
            check_val("underrun", {31'd0, underrun}, {31'd0, exp_uf});
            check_val("q_left", 32'(exp_q.size()), 32'd0);
            exp_row = (exp_row + 1) % 8;
            uf_prev = exp_uf;
        end
        exp_q.delete();
    endtask

    // Nine back-to-back frames: nx, ny, base, stride, stall word, injected start cycle
    int cfg_nx[9]     = '{3, 1, 1, 0, 2, 0, 1, 0, 2};
    int cfg_ny[9]     = '{3, 0, 1, 1, 1, 0, 2, 3, 0};
    int cfg_stall[9]  = '{0, 0, 3, 0, 0, 0, 0, 0, 0};
    int cfg_inj[9]    = '{0, 0, 0, 0, 40, 0, 0, 0, 0};
    logic [15:0] cfg_base[9]   = '{16'h0001, 16'h1357, 16'hC001, 16'h8421, 16'hBEEF,
                                   16'h7FFE, 16'h0F0F, 16'hFFFF, 16'h2468};
    logic [15:0] cfg_stride[9] = '{16'h0001, 16'h1111, 16'h0101, 16'h0F00, 16'h0013,
                                   16'h0000, 16'h3030, 16'hFFFF, 16'h0202};

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0;
        num_modules_x = '0; num_modules_y = '0;
        word_data = '0; word_valid = 1'b0;
        exp_row = 0; uf_prev = 1'b0;
        stop_src = 1'b0; all_taken = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset_outs",
                  {20'd0, word_ready, i2s_data, i2s_clk_en, busy, frame_done, underrun, row_num}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_outs",
                  {20'd0, word_ready, i2s_data, i2s_clk_en, busy, frame_done, underrun, row_num}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame(cfg_nx[i], cfg_ny[i], cfg_base[i], cfg_stride[i], cfg_stall[i], cfg_inj[i], 0);
        end

        // reset in the middle of the payload of a 3/3 frame
        run_frame(3, 3, 16'h4000, 16'h0003, 0, 0, 100);
        repeat (2) @(negedge clk);
        check_val("reset_hold",
                  {20'd0, word_ready, i2s_data, i2s_clk_en, busy, frame_done, underrun, row_num}, 32'd0);
        rst_n   = 1'b1;
        exp_row = 0;
        uf_prev = 1'b0;

        // single-word frame after reset
        run_frame(0, 0, 16'hA5A5, 16'h0000, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
